// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: turns signed samples into rate-coded spike trains.
// Each accepted sample is encoded over WINDOW enabled cycles. Spike count
// is floor(|x|*WINDOW/FS), and spikes are spread evenly by a first-order
// accumulator. Spike polarity follows the sample sign.
module spike_rate_encoder #(
    parameter int DATA_W = 8,
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              pos_out,
    output logic              neg_out,
    output logic              busy,
    output logic              window_done,
    output logic [CNT_W-1:0]  spike_cnt
);

    // Full scale, at sample width (also the most negative code) and with one
    // guard bit for the accumulator sum.
    localparam int unsigned       FS_I = 32'd1 << (DATA_W - 1);
    localparam logic [DATA_W-1:0] FS_N = DATA_W'(FS_I);
    localparam logic [DATA_W:0]   FS_W = {1'b0, FS_N};
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(WINDOW - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic                sign_q, sign_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    spk_q, spk_d;
    logic                pos_q, pos_d;
    logic                neg_q, neg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   mag_in;
    logic [DATA_W:0]     sum;
    logic                spike;
    logic                last_step;
    logic                accept;

    // Magnitude of the offered sample; the most negative code saturates to FS-1.
    always_comb begin
        mag_in = in_data;
        if (in_data[DATA_W-1]) begin
            if (in_data == FS_N) begin
                mag_in = FS_N - DATA_W'(1);
            end else begin
                mag_in = '0 - in_data;
            end
        end
    end

    // Accumulator step and the handshake decode shared by the FSM.
    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, mag_q};
        spike     = (sum >= FS_W);
        last_step = (cnt_q == LAST);
        in_ready  = ~rst & ((state_q == S_IDLE) |
                            ((state_q == S_RUN) & en & last_step));
        accept    = in_valid & in_ready;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        spk_d   = spk_q;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    spk_d   = '0;
                    mag_d   = mag_in;
                    sign_d  = in_data[DATA_W-1];
                end
            end
            S_RUN: begin
                if (en) begin
                    // sum < 2*FS always, so subtracting FS in DATA_W bits is exact
                    acc_d = spike ? (sum[DATA_W-1:0] - FS_N) : sum[DATA_W-1:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (spike) begin
                        pos_d = ~sign_q;
                        neg_d = sign_q;
                        spk_d = spk_q + CNT_W'(1);
                    end
                    if (last_step) begin
                        done_d = 1'b1;
                        // The final spike still goes out; a same-edge accept
                        // restarts the window with no idle gap.
                        if (accept) begin
                            busy_d = 1'b1;
                            acc_d  = '0;
                            cnt_d  = '0;
                            spk_d  = '0;
                            mag_d  = mag_in;
                            sign_d = in_data[DATA_W-1];
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any window silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            spk_q   <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            spk_q   <= spk_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pos_out     = pos_q;
    assign neg_out     = neg_q;
    assign busy        = busy_q;
    assign window_done = done_q;
    assign spike_cnt   = spk_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: the driver pushes one expected
// window per accepted sample; the monitor checks every edge against a
// floor(mag*k/FS) reference.
module tb_spike_rate_encoder;

    localparam int DATA_W = 8;
    localparam int WINDOW = 16;
    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int FS     = 1 << (DATA_W - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              pos_out;
    logic              neg_out;
    logic              busy;
    logic              window_done;
    logic [CNT_W-1:0]  spike_cnt;

    typedef struct {
        int mag;
        bit sign;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    spike_rate_encoder #(.DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .pos_out(pos_out),
        .neg_out(neg_out), .busy(busy), .window_done(window_done),
        .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t make_exp(input int d);
        exp_t e;
        int m;
        m = (d < 0) ? -d : d;
        if (m > FS - 1) m = FS - 1;
        e.mag  = m;
        e.sign = (d < 0);
        return e;
    endfunction

    // One clock: drive inputs at negedge, record an accept, wait past the edge.
    task automatic tick(input bit r, input bit e, input bit v, input int d, output bit acc);
        bit idle;
        @(negedge clk);
        rst = r; en = e; in_valid = v; in_data = d[DATA_W-1:0];
        #1;
        idle = (q.size() == 0);
        if (r) chk("ready_in_reset", in_ready, 0);
        else if (idle) chk("ready_idle", in_ready, 1);
        acc = !r && v && in_ready;
        if (acc) q.push_back(make_exp(d));
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input int d, input int en_pct, output int n);
        bit a = 1'b0;
        n = 0;
        while (!a && n < 200) begin
            tick(1'b0, ($urandom_range(99) < en_pct), 1'b1, d, a);
            n++;
        end
        if (!a) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle_ticks(input int cnt, input bit e);
        bit a;
        for (int i = 0; i < cnt; i++) tick(1'b0, e, 1'b0, 0, a);
    endtask

    task automatic drain(input int en_pct, output int n);
        bit a;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            tick(1'b0, ($urandom_range(99) < en_pct), 1'b0, 0, a);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: follows the front expectation through enabled steps.
    initial begin
        int   k = 0;
        int   pc = 0;
        int   nc = 0;
        int   last_cnt = 0;
        bit   busy_p = 1'b0;
        bit   sp;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                if (busy_p && q.size() > 0) void'(q.pop_front());
                k = 0; pc = 0; nc = 0; last_cnt = 0;
                chk("rst_outs", {pos_out, neg_out, busy, window_done, spike_cnt}, 0);
            end else if (busy_p) begin
                e = q[0];
                chk("pos_neg_excl", pos_out & neg_out, 0);
                if (en) begin
                    k++;
                    sp = ((e.mag * k) / FS) > ((e.mag * (k - 1)) / FS);
                    chk("pos_step", pos_out, sp && !e.sign);
                    chk("neg_step", neg_out, sp && e.sign);
                    pc += pos_out; nc += neg_out;
                    if (k == WINDOW) begin
                        chk("done_pulse", window_done, 1);
                        chk("pos_total", pc, e.sign ? 0 : (e.mag * WINDOW) / FS);
                        chk("neg_total", nc, e.sign ? (e.mag * WINDOW) / FS : 0);
                        void'(q.pop_front());
                        last_cnt = (q.size() > 0) ? 0 : (e.mag * WINDOW) / FS;
                        chk("busy_end", busy, q.size() > 0);
                        chk("cnt_final", spike_cnt, last_cnt);
                        k = 0; pc = 0; nc = 0;
                    end else begin
                        chk("done_early", window_done, 0);
                        chk("cnt_step", spike_cnt, (e.mag * k) / FS);
                        chk("busy_run", busy, 1);
                    end
                end else begin
                    chk("stall_outs", {pos_out, neg_out, window_done}, 0);
                    chk("stall_cnt", spike_cnt, (e.mag * k) / FS);
                    chk("busy_stall", busy, 1);
                end
            end else begin
                chk("idle_outs", {pos_out, neg_out, window_done}, 0);
                chk("busy_idle", busy, q.size() > 0);
                chk("cnt_idle", spike_cnt, (q.size() > 0) ? 0 : last_cnt);
            end
            busy_p = (q.size() > 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int n;
        int n2;
        int d;
        int picks[6] = '{127, -128, 0, 1, -1, 64};

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 0, a);
        idle_ticks(2, 1'b1);

        offer(64, 100, n);   drain(100, n);
        offer(-128, 100, n); drain(100, n);
        offer(0, 100, n);    drain(100, n);

        // back-to-back: second sample is held until the last window cycle
        offer(32, 100, n);
        offer(-96, 100, n2);
        chk("b2b_wait", n2, WINDOW);
        drain(100, n);
        idle_ticks(2, 1'b1);

        // stall in mid-window delays completion by the stall length
        offer(64, 100, n);
        idle_ticks(6, 1'b1);
        idle_ticks(5, 1'b0);
        drain(100, n);
        chk("stall_latency", 6 + 5 + n, WINDOW + 5);

        // reset during window cycle 7
        offer(127, 100, n);
        idle_ticks(6, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 0, a);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        idle_ticks(3, 1'b1);

        // randomized traffic with stalls and occasional back-to-back samples
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) d = picks[$urandom_range(5)];
            else d = int'($urandom_range(255)) - 128;
            offer(d, 80, n);
            if ($urandom_range(2) != 0) idle_ticks($urandom_range(20), $urandom_range(1));
        end
        drain(80, n);
        idle_ticks(3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Converts signed real-valued samples into rate-coded pos/neg spike trains for the neuron input pairs (pos_in/neg_in).
- Sits upstream of the neuron layer, on the transmitting end of the spike interface that the neurons receive.
- Each accepted sample occupies one window of WINDOW enabled cycles.
- Spike count per window is proportional to sample magnitude; spike polarity follows the sample sign.

Parameters:
- DATA_W, 8, sample width in bits, signed two's complement. Full scale FS = 2^(DATA_W-1).
- WINDOW, 16, enabled cycles per encoding window (>=2).
- CNT_W, $clog2(WINDOW+1), width of the counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  window advance enable; 0 stalls an active window.
- in_valid  input  1  sample offered.
- in_ready  output  1  encoder can accept a sample this cycle (combinational).
- in_data  input  DATA_W  signed sample.
- pos_out  output  1  registered positive spike pulse.
- neg_out  output  1  registered negative spike pulse.
- busy  output  1  registered; high while a window is active.
- window_done  output  1  registered 1-cycle pulse after the last window cycle.
- spike_cnt  output  CNT_W  registered spikes emitted in the current or last window.

Behaviour:
- States are IDLE and RUN.
- Reset: state=IDLE, acc=0, cnt=0, pos_out=neg_out=busy=window_done=0, spike_cnt=0. in_ready is forced to 0 while rst=1.
- in_ready = (state==IDLE) | (state==RUN & en & cnt==WINDOW-1).
- Accept occurs on an edge where in_valid & in_ready. On accept:
  - mag = |in_data|; the value -FS saturates to FS-1.
  - sign = in_data[DATA_W-1]; acc=0; cnt=0; spike_cnt=0; state=RUN; busy=1.
- RUN with en=1, each edge:
  - s = acc + mag (width DATA_W+1).
  - Spike condition: s >= FS. If true, acc = s - FS; otherwise acc = s.
  - On a spike, pos_out=~sign and neg_out=sign, and spike_cnt increments.
  - With no spike, pos_out=neg_out=0.
  - cnt increments.
- RUN with en=0: acc, cnt and spike_cnt hold; pos_out=neg_out=0; in_ready=0 unless in IDLE.
- End of window, on the edge where cnt==WINDOW-1 and en=1:
  - The final spike decision is made.
  - window_done=1 on the next cycle; spike_cnt holds the final value until the next accept.
  - If a sample is accepted on that same edge, RUN restarts (back-to-back, no idle gap) and busy stays 1.
  - Otherwise state=IDLE and busy=0.
- Spike count per window = floor(mag*WINDOW/FS). Spikes are evenly dithered.
- The first spike can appear no earlier than the edge after the first enabled RUN cycle; latency from accept is at least 1 cycle.
- pos_out and neg_out are never high together.
- mag=0 gives no spikes, but the full window still runs and window_done still pulses.
- A sample offered while in_ready=0 is not consumed; the source holds it.
- rst mid-window: abort immediately, go to reset values, no window_done.
- Arithmetic is unsigned on mag/acc; acc < FS is invariant after every update.

Test Plan:
- Reset release, in_data=64, valid 1 cycle, en=1 →
  - pos_out high on window cycles 2,4,...,16 (8 pulses).
  - neg_out=0.
  - window_done pulse 1 cycle after cycle 16.
  - spike_cnt=8.
- in_data=-128 (0x80) →
  - saturates to 127.
  - neg_out pulses on window cycles 2..16 (15 pulses).
  - spike_cnt=15; pos_out=0.
- in_data=0 → no spikes for 16 cycles; window_done still pulses; spike_cnt=0.
- Back-to-back: in_valid held with samples 32 then -96 →
  - second accept on the last cycle of the first window, with busy continuously 1.
  - spike counts 4 (pos) then 12 (neg).
- Stall: sample 64, en=0 for 5 cycles mid-window →
  - outputs 0 and counters frozen during the stall.
  - 8 spikes total; window_done is delayed by 5 cycles.
- rst asserted at window cycle 7 of sample 127 →
  - next cycle all outputs 0, busy=0, no window_done.
  - in_ready=1 after rst drops.
